// File: rtl/rcu_pkg.sv
// Shared state encoding and default timing constants for the RCU PLL sequencer.
// The configuration width comes from the project-wide RCU_CLK_CFG_WIDTH define.
`ifndef RCU_CLK_CFG_WIDTH
`define RCU_CLK_CFG_WIDTH 8
`endif

package rcu_pkg;

    localparam int DEF_CFG_WIDTH    = `RCU_CLK_CFG_WIDTH;
    localparam int DEF_SWITCH_CYC   = 4;
    localparam int DEF_SETTLE_CYC   = 16;
    localparam int DEF_LOCK_TIMEOUT = 4096;
    localparam int DEF_LOCK_STABLE  = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BYPASS,
        ST_PWRDN,
        ST_PWRUP,
        ST_STABLE,
        ST_SWITCH,
        ST_RUN
    } rcu_pll_state_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/rcu_sync2.sv
// Generic two-flop synchronizer with synchronous active-high reset.
module rcu_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rcu_pll_ctrl.sv
// RCU PLL sequencer: bypass, power down, load config, power up, qualify lock, switch to PLL.
// Runs on the reference clock and watches the synchronized lock flag for timeout and loss.
module rcu_pll_ctrl
    import rcu_pkg::*;
#(
    parameter int CFG_WIDTH    = DEF_CFG_WIDTH,
    parameter int SWITCH_CYC   = DEF_SWITCH_CYC,
    parameter int SETTLE_CYC   = DEF_SETTLE_CYC,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
    parameter int LOCK_STABLE  = DEF_LOCK_STABLE
) (
    input  logic                 ref_clk_i,
    input  logic                 rst_i,
    input  logic                 req_valid_i,
    output logic                 req_ready_o,
    input  logic                 req_en_i,
    input  logic [CFG_WIDTH-1:0] req_cfg_i,
    input  logic                 pll_lock_i,
    output logic                 pll_en_o,
    output logic [CFG_WIDTH-1:0] clk_cfg_o,
    output logic                 clk_sel_o,
    output logic                 locked_o,
    output logic                 busy_o,
    output logic                 err_o,
    output logic                 lock_lost_o
);

    localparam int PH_W  = $clog2(max3(SWITCH_CYC, SETTLE_CYC, LOCK_STABLE) + 1);
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);

    rcu_pll_state_e       state_q, state_d;
    logic [PH_W-1:0]      phase_q, phase_d;
    logic [TMO_W-1:0]     tmo_q, tmo_d;
    logic                 en_lat_q, en_lat_d;
    logic [CFG_WIDTH-1:0] cfg_lat_q, cfg_lat_d;
    logic                 pll_en_q, pll_en_d;
    logic [CFG_WIDTH-1:0] clk_cfg_q, clk_cfg_d;
    logic                 clk_sel_q, clk_sel_d;
    logic                 locked_q, locked_d;
    logic                 busy_q, busy_d;
    logic                 err_q, err_d;
    logic                 lock_lost_q, lock_lost_d;
    logic                 req_ready_q, req_ready_d;
    logic                 lock_gated;
    logic                 lock_synced;
    logic                 accept;
    logic                 tmo_hit;

    // A disabled PLL can report garbage on its lock pin, so gate before syncing.
    assign lock_gated = pll_lock_i & pll_en_q;

    rcu_sync2 #(.WIDTH(1)) u_lock_sync (
        .clk_i (ref_clk_i),
        .rst_i (rst_i),
        .d_i   (lock_gated),
        .q_o   (lock_synced)
    );

    assign accept  = req_valid_i && req_ready_q;
    assign tmo_hit = (tmo_q == TMO_W'(LOCK_TIMEOUT - 1));

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q + 1'b1;
        tmo_d       = tmo_q;
        en_lat_d    = en_lat_q;
        cfg_lat_d   = cfg_lat_q;
        pll_en_d    = pll_en_q;
        clk_cfg_d   = clk_cfg_q;
        clk_sel_d   = clk_sel_q;
        locked_d    = locked_q;
        err_d       = err_q;
        lock_lost_d = 1'b0;

        case (state_q)
            ST_IDLE, ST_RUN: begin
                phase_d = '0;
                if (accept) begin
                    state_d   = ST_BYPASS;
                    en_lat_d  = req_en_i;
                    cfg_lat_d = req_cfg_i;
                    err_d     = 1'b0;
                    clk_sel_d = 1'b0;
                    locked_d  = 1'b0;
                end else if (state_q == ST_RUN && !lock_synced) begin
                    state_d     = ST_PWRUP;
                    tmo_d       = '0;
                    clk_sel_d   = 1'b0;
                    locked_d    = 1'b0;
                    lock_lost_d = 1'b1;
                end
            end
            ST_BYPASS: begin
                if (phase_q == PH_W'(SWITCH_CYC - 1)) begin
                    state_d   = ST_PWRDN;
                    phase_d   = '0;
                    pll_en_d  = 1'b0;
                    clk_cfg_d = cfg_lat_q;
                end
            end
            ST_PWRDN: begin
                if (phase_q == PH_W'(SETTLE_CYC - 1)) begin
                    phase_d = '0;
                    if (en_lat_q) begin
                        state_d  = ST_PWRUP;
                        pll_en_d = 1'b1;
                        tmo_d    = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_PWRUP, ST_STABLE: begin
                tmo_d = tmo_q + 1'b1;
                // Timeout wins even if the stable count completes on the same cycle.
                if (tmo_hit) begin
                    state_d   = ST_IDLE;
                    phase_d   = '0;
                    tmo_d     = '0;
                    pll_en_d  = 1'b0;
                    err_d     = 1'b1;
                    clk_sel_d = 1'b0;
                    locked_d  = 1'b0;
                end else if (!lock_synced) begin
                    state_d = ST_PWRUP;
                    phase_d = '0;
                end else if (state_q == ST_PWRUP) begin
                    state_d = ST_STABLE;
                    phase_d = PH_W'(1);
                end else if (phase_q == PH_W'(LOCK_STABLE - 1)) begin
                    state_d   = ST_SWITCH;
                    phase_d   = '0;
                    clk_sel_d = 1'b1;
                end
            end
            ST_SWITCH: begin
                if (phase_q == PH_W'(SWITCH_CYC - 1)) begin
                    state_d  = ST_RUN;
                    phase_d  = '0;
                    locked_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                phase_d = '0;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE) || (state_d == ST_RUN);
        busy_d      = !req_ready_d;
    end

    always_ff @(posedge ref_clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            tmo_q       <= '0;
            en_lat_q    <= 1'b0;
            cfg_lat_q   <= '0;
            pll_en_q    <= 1'b0;
            clk_cfg_q   <= '0;
            clk_sel_q   <= 1'b0;
            locked_q    <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
            lock_lost_q <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            tmo_q       <= tmo_d;
            en_lat_q    <= en_lat_d;
            cfg_lat_q   <= cfg_lat_d;
            pll_en_q    <= pll_en_d;
            clk_cfg_q   <= clk_cfg_d;
            clk_sel_q   <= clk_sel_d;
            locked_q    <= locked_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
            lock_lost_q <= lock_lost_d;
            req_ready_q <= req_ready_d;
        end
    end

    assign req_ready_o = req_ready_q;
    assign pll_en_o    = pll_en_q;
    assign clk_cfg_o   = clk_cfg_q;
    assign clk_sel_o   = clk_sel_q;
    assign locked_o    = locked_q;
    assign busy_o      = busy_q;
    assign err_o       = err_q;
    assign lock_lost_o = lock_lost_q;

endmodule

// File: tb/tb_rcu_pll_ctrl.sv
// Directed bench for rcu_pll_ctrl: expected output snapshots are queued with a due cycle
// when stimulus is applied and compared once the DUT reaches that cycle.
module tb_rcu_pll_ctrl;
    import rcu_pkg::*;

    localparam int CW = DEF_CFG_WIDTH;
    localparam int VW = CW + 7;

    typedef logic [VW-1:0] vec_t;
    typedef struct {
        string tag;
        int    due;
        vec_t  exp;
    } sb_entry_t;

    logic          ref_clk_i = 1'b0;
    logic          rst_i;
    logic          req_valid_i;
    logic          req_ready_o;
    logic          req_en_i;
    logic [CW-1:0] req_cfg_i;
    logic          pll_lock_i;
    logic          pll_en_o;
    logic [CW-1:0] clk_cfg_o;
    logic          clk_sel_o;
    logic          locked_o;
    logic          busy_o;
    logic          err_o;
    logic          lock_lost_o;

    sb_entry_t sb_q[$];
    int        cyc    = 0;
    int        checks = 0;
    int        errors = 0;
    vec_t      reset_v;

    rcu_pll_ctrl dut (
        .ref_clk_i   (ref_clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_en_i    (req_en_i),
        .req_cfg_i   (req_cfg_i),
        .pll_lock_i  (pll_lock_i),
        .pll_en_o    (pll_en_o),
        .clk_cfg_o   (clk_cfg_o),
        .clk_sel_o   (clk_sel_o),
        .locked_o    (locked_o),
        .busy_o      (busy_o),
        .err_o       (err_o),
        .lock_lost_o (lock_lost_o)
    );

    always #5 ref_clk_i = ~ref_clk_i;

    // Snapshot order: ready, pll_en, clk_sel, locked, busy, err, lock_lost, clk_cfg.
    function automatic vec_t mk(input bit rdy, input bit en, input bit sel, input bit lck,
                                input bit bsy, input bit err, input bit lost, input int cfg);
        return {rdy, en, sel, lck, bsy, err, lost, CW'(cfg)};
    endfunction

    function automatic vec_t observed();
        return {req_ready_o, pll_en_o, clk_sel_o, locked_o, busy_o, err_o, lock_lost_o, clk_cfg_o};
    endfunction

    task automatic expectIn(input string tag, input int off, input vec_t v);
        sb_q.push_back('{tag, cyc + off, v});
    endtask

    task automatic applyStimulus(input bit valid, input bit en, input int cfg, input bit lock);
        req_valid_i = valid;
        req_en_i    = en;
        req_cfg_i   = CW'(cfg);
        pll_lock_i  = lock;
    endtask

    task automatic checkOutput();
        int   i;
        vec_t obs;
        i   = 0;
        obs = observed();
        while (i < sb_q.size()) begin
            if (sb_q[i].due == cyc) begin
                checks++;
                assert (obs === sb_q[i].exp) else begin
                    errors++;
                    $error("[TB] FAIL %s: observed=%h expected=%h at cycle %0d",
                           sb_q[i].tag, obs, sb_q[i].exp, cyc);
                end
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) begin
            @(posedge ref_clk_i);
            #1;
            cyc++;
            checkOutput();
        end
    endtask

    initial begin
        reset_v = mk(1, 0, 0, 0, 0, 0, 0, 0);
        rst_i   = 1'b1;
        applyStimulus(0, 0, 0, 0);
        expectIn("reset", 2, reset_v);
        waitCycles(2);
        rst_i = 1'b0;

        $display("[TB] power-up to RUN with cfg=5");
        applyStimulus(1, 1, 5, 0);
        expectIn("s1_bypass",     1, mk(0, 0, 0, 0, 1, 0, 0, 0));
        expectIn("s1_cfg_hold",   4, mk(0, 0, 0, 0, 1, 0, 0, 0));
        expectIn("s1_pwrdn",      5, mk(0, 0, 0, 0, 1, 0, 0, 5));
        expectIn("s1_settle",    20, mk(0, 0, 0, 0, 1, 0, 0, 5));
        expectIn("s1_pwrup",     21, mk(0, 1, 0, 0, 1, 0, 0, 5));
        expectIn("s1_prelock",   40, mk(0, 1, 0, 0, 1, 0, 0, 5));
        expectIn("s1_switch",    41, mk(0, 1, 1, 0, 1, 0, 0, 5));
        expectIn("s1_switch_end",44, mk(0, 1, 1, 0, 1, 0, 0, 5));
        expectIn("s1_run",       45, mk(1, 1, 1, 1, 0, 0, 0, 5));
        waitCycles(1);
        applyStimulus(0, 1, 5, 0);
        waitCycles(30);
        applyStimulus(0, 1, 5, 1);
        waitCycles(16);

        $display("[TB] lock loss in RUN and relock");
        applyStimulus(0, 1, 5, 0);
        expectIn("s2_sync_lat",   2, mk(1, 1, 1, 1, 0, 0, 0, 5));
        expectIn("s2_lost",       3, mk(0, 1, 0, 0, 1, 0, 1, 5));
        expectIn("s2_pulse_end",  4, mk(0, 1, 0, 0, 1, 0, 0, 5));
        expectIn("s2_relock_sw", 17, mk(0, 1, 1, 0, 1, 0, 0, 5));
        expectIn("s2_relock",    18, mk(1, 1, 1, 1, 0, 0, 0, 5));
        waitCycles(4);
        applyStimulus(0, 1, 5, 1);
        waitCycles(16);

        $display("[TB] reconfigure to cfg=9 with lock chatter");
        applyStimulus(1, 1, 9, 1);
        expectIn("s3_bypass",        1, mk(0, 1, 0, 0, 1, 0, 0, 5));
        expectIn("s3_busy_ignored",  2, mk(0, 1, 0, 0, 1, 0, 0, 5));
        expectIn("s3_pwrdn",         5, mk(0, 0, 0, 0, 1, 0, 0, 9));
        expectIn("s3_pwrup",        21, mk(0, 1, 0, 0, 1, 0, 0, 9));
        expectIn("s3_chatter_nosw", 31, mk(0, 1, 0, 0, 1, 0, 0, 9));
        expectIn("s3_prelock",      36, mk(0, 1, 0, 0, 1, 0, 0, 9));
        expectIn("s3_switch",       37, mk(0, 1, 1, 0, 1, 0, 0, 9));
        expectIn("s3_run",          41, mk(1, 1, 1, 1, 0, 0, 0, 9));
        waitCycles(1);
        applyStimulus(1, 0, 3, 0);
        waitCycles(1);
        applyStimulus(0, 0, 3, 0);
        waitCycles(19);
        applyStimulus(0, 0, 3, 1);
        waitCycles(5);
        applyStimulus(0, 0, 3, 0);
        waitCycles(1);
        applyStimulus(0, 0, 3, 1);
        waitCycles(15);

        $display("[TB] shut down from RUN");
        applyStimulus(1, 0, 7, 1);
        expectIn("s4_bypass",  1, mk(0, 1, 0, 0, 1, 0, 0, 9));
        expectIn("s4_en_hold", 4, mk(0, 1, 0, 0, 1, 0, 0, 9));
        expectIn("s4_pwrdn",   5, mk(0, 0, 0, 0, 1, 0, 0, 7));
        expectIn("s4_settle", 20, mk(0, 0, 0, 0, 1, 0, 0, 7));
        expectIn("s4_idle",   21, mk(1, 0, 0, 0, 0, 0, 0, 7));
        waitCycles(1);
        applyStimulus(0, 0, 7, 1);
        waitCycles(21);

        $display("[TB] lock timeout");
        applyStimulus(1, 1, 3, 0);
        expectIn("s5_accept",      1, mk(0, 0, 0, 0, 1, 0, 0, 7));
        expectIn("s5_pwrdn",       5, mk(0, 0, 0, 0, 1, 0, 0, 3));
        expectIn("s5_pwrup",      21, mk(0, 1, 0, 0, 1, 0, 0, 3));
        expectIn("s5_tmo_edge", 4116, mk(0, 1, 0, 0, 1, 0, 0, 3));
        expectIn("s5_timeout",  4117, mk(1, 0, 0, 0, 0, 1, 0, 3));
        waitCycles(1);
        applyStimulus(0, 1, 3, 0);
        waitCycles(4117);

        $display("[TB] error clear, reset during STABLE");
        applyStimulus(1, 1, 4, 0);
        expectIn("s6_err_clear",   1, mk(0, 0, 0, 0, 1, 0, 0, 3));
        expectIn("s6_pwrdn",       5, mk(0, 0, 0, 0, 1, 0, 0, 4));
        expectIn("s6_pwrup",      21, mk(0, 1, 0, 0, 1, 0, 0, 4));
        expectIn("s6_rst_stable", 27, reset_v);
        waitCycles(1);
        applyStimulus(0, 1, 4, 0);
        waitCycles(20);
        applyStimulus(0, 1, 4, 1);
        waitCycles(5);
        rst_i = 1'b1;
        waitCycles(1);
        rst_i = 1'b0;

        $display("[TB] reset during SWITCH");
        applyStimulus(1, 1, 6, 1);
        expectIn("s6b_accept",      1, mk(0, 0, 0, 0, 1, 0, 0, 0));
        expectIn("s6b_pwrdn",       5, mk(0, 0, 0, 0, 1, 0, 0, 6));
        expectIn("s6b_pwrup",      21, mk(0, 1, 0, 0, 1, 0, 0, 6));
        expectIn("s6b_prelock",    30, mk(0, 1, 0, 0, 1, 0, 0, 6));
        expectIn("s6b_switch",     31, mk(0, 1, 1, 0, 1, 0, 0, 6));
        expectIn("s6b_rst_switch", 33, reset_v);
        waitCycles(1);
        applyStimulus(0, 1, 6, 1);
        waitCycles(31);
        rst_i = 1'b1;
        waitCycles(1);
        rst_i = 1'b0;

        $display("[TB] clean sequence after reset");
        applyStimulus(1, 1, 10, 1);
        expectIn("s6c_switch", 34, mk(0, 1, 1, 0, 1, 0, 0, 10));
        expectIn("s6c_run",    35, mk(1, 1, 1, 1, 0, 0, 0, 10));
        waitCycles(1);
        applyStimulus(0, 1, 10, 1);
        waitCycles(35);

        $display("[TB] request coinciding with lock loss");
        applyStimulus(0, 1, 10, 0);
        expectIn("s7_req_wins", 3, mk(0, 1, 0, 0, 1, 0, 0, 10));
        expectIn("s7_pwrdn",    7, mk(0, 0, 0, 0, 1, 0, 0, 11));
        waitCycles(2);
        applyStimulus(1, 1, 11, 0);
        waitCycles(1);
        applyStimulus(0, 1, 11, 0);
        waitCycles(5);

        checks++;
        assert (sb_q.size() == 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_drain: pending=%0d required=0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
